// File: rtl/dac_tx_pkg.sv
// Shared types and constants for the DAC transmit framer.
package dac_tx_pkg;

  // Framer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam int SAMPLE_W         = 16;
  localparam int DEF_DATA_W       = 512;
  localparam int SAMPLES_PER_WORD = DEF_DATA_W / SAMPLE_W;

  // One ramp sample: lane k of a ramp word starting at base
  function automatic logic [SAMPLE_W-1:0] ramp_sample(input logic [SAMPLE_W-1:0] base,
                                                      input int k);
    return base + SAMPLE_W'(k);
  endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// Single-clock FIFO with synchronous flush. Push is ignored when full and
// pop is ignored when empty; flush takes precedence over both.
module dac_tx_fifo #(
  parameter int W     = 513,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == {LW{1'b0}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        level_d = level_q + LW'(1);
      end else if (!do_push && do_pop) begin
        level_d = level_q - LW'(1);
      end else begin
        level_d = level_q;
      end
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/dac_tx_framer.sv
// DAC transmit framer: buffers user sample words, waits for a sync-marked
// word, primes the FIFO and then streams a continuous word stream to the
// JESD TX transport, zero-filling (and counting) on underflow.
// Optional build macro DAC_TX_FRAMER_RAMP_EN adds a test_mode input that
// replaces the FIFO data with a 16-bit counting ramp while in RUN.
module dac_tx_framer
  import dac_tx_pkg::*;
#(
  parameter int DATA_W      = 512,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int CNT_W       = 16
) (
  input  logic                          link_clk,
  input  logic                          link_areset_n,
  input  logic                          enable,
  input  logic                          clear_cnt,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_sync,
  input  logic                          din_vld,
  output logic                          din_ready,
  input  logic                          tx_ready,
`ifdef DAC_TX_FRAMER_RAMP_EN
  input  logic                          test_mode,
`endif
  output logic [DATA_W-1:0]             tx_data,
  output logic                          tx_sync,
  output logic                          tx_valid,
  output logic                          underflow,
  output logic                          underflow_sticky,
  output logic [CNT_W-1:0]              underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_sync_q, tx_sync_d;
  logic                tx_valid_q, tx_valid_d;
  logic                underflow_q, underflow_d;
  logic                sticky_q, sticky_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LW-1:0]       fifo_level;
  logic [DATA_W:0]     fifo_dout;
  logic                ready_s;

  // Words are offered to the FIFO only outside IDLE and while it has room
  assign ready_s   = (state_q != IDLE) & ~fifo_full;
  assign din_ready = ready_s;

  dac_tx_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (link_clk),
    .rst_n (link_areset_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({din_sync, din}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef DAC_TX_FRAMER_RAMP_EN
  localparam int N_SAMP = DATA_W / SAMPLE_W;

  logic [SAMPLE_W-1:0] base_q, base_d;
  logic                ramp_first_q, ramp_first_d;
  logic [DATA_W-1:0]   ramp_word;

  // Ramp word: lane k carries base + k
  always_comb begin
    ramp_word = {DATA_W{1'b0}};
    for (int k = 0; k < N_SAMP; k++) begin
      ramp_word[k*SAMPLE_W +: SAMPLE_W] = ramp_sample(base_q, k);
    end
  end
`endif

  // Control FSM, output word selection and underflow accounting
  always_comb begin
    state_d     = state_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_sync_d   = tx_sync_q;
    underflow_d = 1'b0;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
`ifdef DAC_TX_FRAMER_RAMP_EN
    base_d       = base_q;
    ramp_first_d = ramp_first_q;
`endif

    if (!enable) begin
      state_d    = IDLE;
      fifo_flush = 1'b1;
      tx_data_d  = {DATA_W{1'b0}};
      tx_sync_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fifo_flush = 1'b1;
          tx_data_d  = {DATA_W{1'b0}};
          tx_sync_d  = 1'b0;
          state_d    = ALIGN;
        end
        ALIGN: begin
          // Non-sync words are accepted and discarded until a frame start
          if (din_vld && ready_s && din_sync) begin
            fifo_push = 1'b1;
            state_d   = FILL;
          end else begin
            state_d = ALIGN;
          end
        end
        FILL: begin
          fifo_push = din_vld & ready_s;
          if (fifo_level >= PRIME_LVL) begin
            state_d = RUN;
          end else begin
            state_d = FILL;
          end
        end
        RUN: begin
          fifo_push = din_vld & ready_s;
          if (tx_ready) begin
`ifdef DAC_TX_FRAMER_RAMP_EN
            if (test_mode) begin
              tx_data_d    = ramp_word;
              tx_sync_d    = ramp_first_q;
              ramp_first_d = 1'b0;
              base_d       = base_q + SAMPLE_W'(N_SAMP);
            end else
`endif
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              tx_data_d = fifo_dout[DATA_W-1:0];
              tx_sync_d = fifo_dout[DATA_W];
            end else begin
              tx_data_d   = {DATA_W{1'b0}};
              tx_sync_d   = 1'b0;
              underflow_d = 1'b1;
            end
          end else begin
            tx_data_d = tx_data_q;
            tx_sync_d = tx_sync_q;
          end
        end
        default: begin
          state_d    = IDLE;
          fifo_flush = 1'b1;
        end
      endcase
    end

    // A clear in the same cycle as an underflow leaves the counter at zero
    if (clear_cnt) begin
      cnt_d    = {CNT_W{1'b0}};
      sticky_d = 1'b0;
    end else if (underflow_d) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
    end

`ifdef DAC_TX_FRAMER_RAMP_EN
    // Ramp restarts from zero with a sync word every time RUN is re-entered
    if (state_d != RUN) begin
      base_d       = {SAMPLE_W{1'b0}};
      ramp_first_d = 1'b1;
    end else begin
      base_d       = base_d;
      ramp_first_d = ramp_first_d;
    end
`endif

    tx_valid_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge link_clk or negedge link_areset_n) begin
    if (!link_areset_n) begin
      state_q     <= IDLE;
      tx_data_q   <= {DATA_W{1'b0}};
      tx_sync_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_sync_q   <= tx_sync_d;
      tx_valid_q  <= tx_valid_d;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef DAC_TX_FRAMER_RAMP_EN
  // Ramp generator registers
  always_ff @(posedge link_clk or negedge link_areset_n) begin
    if (!link_areset_n) begin
      base_q       <= {SAMPLE_W{1'b0}};
      ramp_first_q <= 1'b1;
    end else begin
      base_q       <= base_d;
      ramp_first_q <= ramp_first_d;
    end
  end
`endif

  assign tx_data          = tx_data_q;
  assign tx_sync          = tx_sync_q;
  assign tx_valid         = tx_valid_q;
  assign underflow        = underflow_q;
  assign underflow_sticky = sticky_q;
  assign underflow_cnt    = cnt_q;
  assign level            = fifo_level;

endmodule
